icache_refill_ctrl: RTL

- Miss-handling engine directly below the instruction cache in the IF stage.
- On an instruction-cache miss it fetches one 256-bit block from backing memory, one 32-bit word at a time, starting with the missed word (critical-word-first) and wrapping within the block.
- It delivers the assembled block for the cache line write and holds the PC and IF/ID stall active until the fill completes.
- Addresses are word addresses, consistent with the PC incrementing by 1.

---
 rtl/icache_refill_ctrl_if.sv | 33 +++
 rtl/icache_refill_ctrl.sv | 84 ++++++++
 2 files changed

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: miss/refill bus between the I-cache, the refill controller and backing memory
//   miss_req/miss_addr            : miss report from the cache
//   mem_req/mem_addr              : word read request to memory
//   mem_ack/mem_rdata             : memory read return
//   stall                         : PC and IF/ID hold
//   crit_valid/crit_word          : missed instruction word
//   block_valid/block_addr/block_out : assembled line for the cache write
interface icache_refill_ctrl_if #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 32
);
  logic                          miss_req;
  logic [ADDR_W-1:0]             miss_addr;
  logic                          mem_req;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_ack;
  logic [DATA_W-1:0]             mem_rdata;
  logic                          stall;
  logic                          crit_valid;
  logic [DATA_W-1:0]             crit_word;
  logic                          block_valid;
  logic [ADDR_W-1:0]             block_addr;
  logic [DATA_W*BLOCK_WORDS-1:0] block_out;
  modport master (
    output miss_req, miss_addr, mem_ack, mem_rdata,
    input  mem_req, mem_addr, stall, crit_valid, crit_word, block_valid, block_addr, block_out
  );
  modport slave (
    input  miss_req, miss_addr, mem_ack, mem_rdata,
    output mem_req, mem_addr, stall, crit_valid, crit_word, block_valid, block_addr, block_out
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: critical-word-first I-cache line refill engine
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : icache_refill_ctrl_if slave (miss in, memory request/return, stall, critical word, line out)
module icache_refill_ctrl #(
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 32
) (
  input logic                 clk,
  input logic                 reset,
  icache_refill_ctrl_if.slave bus
);
  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int BW = DATA_W * BLOCK_WORDS;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] base_q, mem_addr_q, block_addr_q;
  logic [OW-1:0]     off_q, cnt_q;
  logic              mem_req_q, stall_q, crit_valid_q, block_valid_q;
  logic [DATA_W-1:0] crit_word_q;
  logic [BW-1:0]     block_out_q;
  logic [OW-1:0]     slot, slot_n;
  // slot index wraps naturally in OW bits, keeping every request inside the block
  assign slot   = off_q + cnt_q;
  assign slot_n = slot + 1'b1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      off_q         <= '0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      stall_q       <= 1'b0;
      crit_valid_q  <= 1'b0;
      crit_word_q   <= '0;
      block_valid_q <= 1'b0;
      block_addr_q  <= '0;
      block_out_q   <= '0;
    end else begin
      crit_valid_q  <= 1'b0;
      block_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.miss_req) begin
          base_q     <= {bus.miss_addr[ADDR_W-1:OW], {OW{1'b0}}};
          off_q      <= bus.miss_addr[OW-1:0];
          cnt_q      <= '0;
          mem_req_q  <= 1'b1;
          mem_addr_q <= bus.miss_addr;
          stall_q    <= 1'b1;
          state_q    <= FILL;
        end
        FILL: if (bus.mem_ack) begin
          block_out_q[slot*DATA_W +: DATA_W] <= bus.mem_rdata;
          cnt_q      <= cnt_q + 1'b1;
          mem_addr_q <= {base_q[ADDR_W-1:OW], slot_n};
          if (cnt_q == '0) begin
            crit_valid_q <= 1'b1;
            crit_word_q  <= bus.mem_rdata;
          end
          if (cnt_q == OW'(BLOCK_WORDS-1)) begin
            mem_req_q     <= 1'b0;
            block_valid_q <= 1'b1;
            block_addr_q  <= base_q;
            state_q       <= DONE;
          end
        end
        default: begin
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.stall       = stall_q;
  assign bus.crit_valid  = crit_valid_q;
  assign bus.crit_word   = crit_word_q;
  assign bus.block_valid = block_valid_q;
  assign bus.block_addr  = block_addr_q;
  assign bus.block_out   = block_out_q;
endmodule
